// File: rtl/netwalk_packet_out_serializer.sv
// Buffers modified packet headers in a small FIFO and streams each one out MSB word first
// on a valid/ready bus. Headers that arrive while the FIFO is full are dropped and counted.
module netwalk_packet_out_serializer #(
  parameter int HDR_WIDTH  = 512,
  parameter int BUS_WIDTH  = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [HDR_WIDTH-1:0]          pkt_header_in,
  input  logic                          packet_in_enable,
  output logic [BUS_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          drop_count
);

  localparam int BEATS  = HDR_WIDTH / BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t               state, state_next;
  logic [BEAT_W-1:0]    beat, beat_next;
  logic [HDR_WIDTH-1:0] shift_reg, shift_next;

  logic [HDR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level;

  logic handshake, last_beat, fifo_nonempty, pop, push;

  assign fifo_nonempty = (level != '0);
  assign last_beat     = (beat == BEAT_W'(BEATS - 1));
  assign handshake     = out_valid & out_ready;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a header then.
  assign push = packet_in_enable & ((level < LVL_W'(FIFO_DEPTH)) | pop);

  always_comb begin
    state_next = state;
    beat_next  = beat;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          beat_next  = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (!last_beat) begin
            beat_next  = beat + BEAT_W'(1);
            shift_next = shift_reg << BUS_WIDTH;
          end else if (fifo_nonempty) begin
            // Reload straight from the FIFO so consecutive headers have no idle beat between them.
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            beat_next  = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      beat      <= beat_next;
      shift_reg <= shift_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pkt_header_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level    <= level + LVL_W'(push) - LVL_W'(pop);
      overflow <= packet_in_enable & ~push;
      if (packet_in_enable && !push && drop_count != {CNT_WIDTH{1'b1}}) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

  assign out_valid  = (state == SEND);
  assign out_data   = shift_reg[HDR_WIDTH-1 -: BUS_WIDTH];
  assign out_sop    = out_valid & (beat == '0);
  assign out_eop    = out_valid & last_beat;
  assign fifo_level = level;

endmodule

// File: tb/tb_netwalk_packet_out_serializer.sv
// Directed scenarios plus a random soak, each cycle compared against a queue-based model of
// the header FIFO and the beat stream of the header currently being sent.
module tb_netwalk_packet_out_serializer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] pkt_header_in = '0;
  logic         packet_in_enable = 1'b0;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_sop;
  logic         out_eop;
  logic [2:0]   fifo_level;
  logic         overflow;
  logic [15:0]  drop_count;

  netwalk_packet_out_serializer dut (
    .clk              (clk),
    .reset            (reset),
    .pkt_header_in    (pkt_header_in),
    .packet_in_enable (packet_in_enable),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_sop          (out_sop),
    .out_eop          (out_eop),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [511:0] fifo_q[$];
  logic [63:0]  cur_q[$];
  bit           exp_ovf   = 1'b0;
  int           exp_drops = 0;

  int peak_level   = 0;
  int valid_cycles = 0;
  int headers_done = 0;

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] randHdr();
    logic [511:0] h;
    for (int i = 0; i < 16; i++) h[32*i +: 32] = $urandom();
    return h;
  endfunction

  // The model works on whole headers and a list of words left to send, not on beat counters.
  task automatic modelStep(input bit en, input logic [511:0] hdr, input bit rdy, input bit rst);
    bit v, hs, pop, push;
    logic [511:0] h;
    if (rst) begin
      fifo_q.delete();
      cur_q.delete();
      exp_ovf   = 1'b0;
      exp_drops = 0;
      return;
    end
    v    = cur_q.size() > 0;
    hs   = v && rdy;
    pop  = (fifo_q.size() > 0) && (!v || (hs && cur_q.size() == 1));
    push = en && (fifo_q.size() < 4 || pop);
    if (hs) void'(cur_q.pop_front());
    if (pop) begin
      h = fifo_q.pop_front();
      for (int i = 0; i < 8; i++) cur_q.push_back(h[511-64*i -: 64]);
    end
    if (push) fifo_q.push_back(hdr);
    exp_ovf = en && !push;
    if (en && !push && exp_drops < 65535) exp_drops++;
  endtask

  task automatic checkCycle();
    bit v;
    v = cur_q.size() > 0;
    checkOutput("out_valid", 512'(out_valid), 512'(v));
    checkOutput("out_sop", 512'(out_sop), 512'(v && cur_q.size() == 8));
    checkOutput("out_eop", 512'(out_eop), 512'(v && cur_q.size() == 1));
    if (v) checkOutput("out_data", 512'(out_data), 512'(cur_q[0]));
    checkOutput("fifo_level", 512'(fifo_level), 512'(fifo_q.size()));
    checkOutput("overflow", 512'(overflow), 512'(exp_ovf));
    checkOutput("drop_count", 512'(drop_count), 512'(exp_drops));
    if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
    if (out_valid === 1'b1) valid_cycles++;
  endtask

  task automatic applyStimulus(input bit en, input logic [511:0] hdr, input bit rdy, input bit rst);
    packet_in_enable = en;
    pkt_header_in    = hdr;
    out_ready        = rdy;
    reset            = rst;
    #1;
    if (out_valid === 1'b1 && out_eop === 1'b1 && rdy) headers_done++;
    @(posedge clk);
    modelStep(en, hdr, rdy, rst);
    #1;
    checkCycle();
  endtask

  initial begin
    logic [511:0] pat;
    logic [511:0] h;
    int done0, vc0;

    for (int i = 0; i < 64; i++) pat[511-8*i -: 8] = 8'((i % 16) * 8'h11);

    $display("[TB] reset");
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("rst_out_data", 512'(out_data), '0);
    checkOutput("rst_out_valid", 512'(out_valid), '0);
    checkOutput("rst_fifo_level", 512'(fifo_level), '0);
    checkOutput("rst_drop_count", 512'(drop_count), '0);

    $display("[TB] single header, ready high");
    done0 = headers_done;
    applyStimulus(1'b1, pat, 1'b1, 1'b0);
    checkOutput("t1_n1_valid", 512'(out_valid), '0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t1_n2_sop", 512'(out_sop), 512'(1));
    checkOutput("t1_beat0", 512'(out_data), 512'(64'h0011223344556677));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t1_beat1", 512'(out_data), 512'(64'h8899AABBCCDDEEFF));
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t1_end_valid", 512'(out_valid), '0);
    checkOutput("t1_headers", 512'(headers_done - done0), 512'(1));

    $display("[TB] single header, ready toggling");
    done0 = headers_done;
    applyStimulus(1'b1, pat, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) applyStimulus(1'b0, '0, bit'(i % 2), 1'b0);
    checkOutput("t2_headers", 512'(headers_done - done0), 512'(1));

    $display("[TB] three back-to-back headers");
    done0 = headers_done;
    vc0 = valid_cycles;
    peak_level = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randHdr(), 1'b1, 1'b0);
    for (int i = 0; i < 26; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t3_headers", 512'(headers_done - done0), 512'(3));
    checkOutput("t3_valid_beats", 512'(valid_cycles - vc0), 512'(24));
    checkOutput("t3_peak_level", 512'(peak_level), 512'(2));

    $display("[TB] overflow with ready low");
    done0 = headers_done;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, randHdr(), 1'b0, 1'b0);
    checkOutput("t4_level_full", 512'(fifo_level), 512'(4));
    checkOutput("t4_overflow", 512'(overflow), 512'(1));
    checkOutput("t4_drop_count", 512'(drop_count), 512'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t4_overflow_pulse", 512'(overflow), '0);
    for (int i = 0; i < 44; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t4_headers", 512'(headers_done - done0), 512'(5));

    $display("[TB] reset mid-packet");
    applyStimulus(1'b1, randHdr(), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    done0 = headers_done;
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("t5_rst_valid", 512'(out_valid), '0);
    checkOutput("t5_rst_level", 512'(fifo_level), '0);
    applyStimulus(1'b1, randHdr(), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t5_no_eop_then_one", 512'(headers_done - done0), 512'(1));

    $display("[TB] write into full FIFO during eop pop");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, randHdr(), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t6_at_eop", 512'(out_eop), 512'(1));
    checkOutput("t6_level_before", 512'(fifo_level), 512'(4));
    h = randHdr();
    applyStimulus(1'b1, h, 1'b1, 1'b0);
    checkOutput("t6_level_after", 512'(fifo_level), 512'(4));
    checkOutput("t6_no_overflow", 512'(overflow), '0);
    checkOutput("t6_drop_count", 512'(drop_count), '0);
    for (int i = 0; i < 44; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] random soak");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(bit'($urandom_range(0, 99) < 45), randHdr(),
                    bit'($urandom_range(0, 99) < 60), 1'b0);
    end
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("soak_drained", 512'(out_valid), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
